// File: rtl/ctrl_lbus_burst_if.sv
// ctrl_lbus_burst_if: signal bundle between the host FIFOs, the controller and
// the crypto-core local bus. The master modport is the controller's view.
// With LBUS_WAIT_EN defined the bundle also carries the lbus_wait input.
interface ctrl_lbus_burst_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] lbus_a;
    logic [DATA_W-1:0] lbus_di;
    logic              lbus_wrn;
    logic [DATA_W-1:0] lbus_do;
    logic              lbus_rdn;
`ifdef LBUS_WAIT_EN
    logic              lbus_wait;
`endif
    logic [7:0]        rd;
    logic              re;
    logic              emp;
    logic              aemp;
    logic [7:0]        wd;
    logic              we;
    logic              ful;
    logic              aful;
    logic              busy;
    logic              err;

`ifdef LBUS_WAIT_EN
    modport master (
        output lbus_a, lbus_di, lbus_wrn, lbus_rdn, re, wd, we, busy, err,
        input  lbus_do, lbus_wait, rd, emp, aemp, ful, aful
    );
    modport slave (
        input  lbus_a, lbus_di, lbus_wrn, lbus_rdn, re, wd, we, busy, err,
        output lbus_do, lbus_wait, rd, emp, aemp, ful, aful
    );
`else
    modport master (
        output lbus_a, lbus_di, lbus_wrn, lbus_rdn, re, wd, we, busy, err,
        input  lbus_do, rd, emp, aemp, ful, aful
    );
    modport slave (
        input  lbus_a, lbus_di, lbus_wrn, lbus_rdn, re, wd, we, busy, err,
        output lbus_do, rd, emp, aemp, ful, aful
    );
`endif
endinterface

// File: rtl/ctrl_lbus_burst.sv
// ctrl_lbus_burst: parses a byte command stream from the host RX FIFO and runs
// single/burst local-bus reads and writes; read words go back to the TX FIFO
// MSB first. Optional macro LBUS_WAIT_EN adds lbus_wait strobe stretching with
// a 255-cycle abort.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nothing in progress, waiting for RX data
// CMD      | fetch and decode the command byte
// ADDR     | fetch address bytes, MSB first, shifted into lbus_a
// LEN      | fetch burst length byte (burst commands only)
// BRANCH   | one cycle to pick the write-data or read path
// WDATA    | fetch one write word, MSB first, shifted into lbus_di
// SETUP    | address/data stable, strobe high, SETUP_CYC cycles
// STROBE   | strobe low, STROBE_CYC cycles (+ lbus_wait extension)
// RDOUT    | push captured read word to TX FIFO, MSB first
// NEXT     | bump address, count down words, loop or finish
//
// Byte fetch phases inside CMD/ADDR/LEN/WDATA: 0 request (re next cycle when
// the FIFO is not busy), 1 re high, 2 rd valid and captured.
module ctrl_lbus_burst #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int SETUP_CYC  = 4,
    parameter int STROBE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_lbus_burst_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CMD    = 4'd1,
        S_ADDR   = 4'd2,
        S_LEN    = 4'd3,
        S_BRANCH = 4'd4,
        S_WDATA  = 4'd5,
        S_SETUP  = 4'd6,
        S_STROBE = 4'd7,
        S_RDOUT  = 4'd8,
        S_NEXT   = 4'd9
    } state_t;

    localparam logic [3:0]  ADDR_LAST = 4'(ADDR_W / 8 - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_W / 8 - 1);
    localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] STROBE_LD = 16'(STROBE_CYC - 1);

    state_t            state_q, state_d;
    logic [1:0]        ph_q, ph_d;
    logic [3:0]        byte_q, byte_d;
    logic [15:0]       tmr_q, tmr_d;
    logic [8:0]        rem_q, rem_d;
    logic              is_wr_q, is_wr_d;
    logic              is_burst_q, is_burst_d;
    logic [ADDR_W-1:0] lbus_a_q, lbus_a_d;
    logic [DATA_W-1:0] lbus_di_q, lbus_di_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              rdn_q, rdn_d;
    logic              wrn_q, wrn_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [7:0]        wd_q, wd_d;
    logic              err_q, err_d;
`ifdef LBUS_WAIT_EN
    logic [7:0]        ext_q, ext_d;
`endif

    logic rd_busy;
    logic wr_busy;
    logic fetch_st;
    logic byte_rdy;
    logic strobe_end;
    logic wait_abort;

    assign rd_busy  = bus.emp | (bus.aemp & re_q);
    assign wr_busy  = bus.ful | (bus.aful & we_q);
    assign fetch_st = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_LEN) || (state_q == S_WDATA);
    assign byte_rdy = fetch_st && (ph_q == 2'd2);

    // strobe release / abort decision once the base strobe width has elapsed
`ifdef LBUS_WAIT_EN
    assign strobe_end = (tmr_q == 16'd0) && !bus.lbus_wait;
    assign wait_abort = (tmr_q == 16'd0) && bus.lbus_wait && (ext_q == 8'd255);
`else
    assign strobe_end = (tmr_q == 16'd0);
    assign wait_abort = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!bus.emp) state_d = S_CMD;
            S_CMD: begin
                if (byte_rdy) begin
                    if (bus.rd[7:2] == 6'd0) state_d = S_ADDR;
                    else                     state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (byte_rdy && byte_q == ADDR_LAST)
                    state_d = is_burst_q ? S_LEN : S_BRANCH;
            end
            S_LEN:    if (byte_rdy) state_d = S_BRANCH;
            S_BRANCH: state_d = is_wr_q ? S_WDATA : S_SETUP;
            S_WDATA:  if (byte_rdy && byte_q == DATA_LAST) state_d = S_SETUP;
            S_SETUP:  if (tmr_q == 16'd0) state_d = S_STROBE;
            S_STROBE: begin
                if (wait_abort)      state_d = S_IDLE;
                else if (strobe_end) state_d = is_wr_q ? S_NEXT : S_RDOUT;
            end
            S_RDOUT:  if (!wr_busy && byte_q == DATA_LAST) state_d = S_NEXT;
            S_NEXT: begin
                if (rem_q == 9'd1) state_d = S_IDLE;
                else               state_d = is_wr_q ? S_WDATA : S_SETUP;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // datapath, timers and registered outputs for the next cycle
    always_comb begin
        ph_d       = 2'd0;
        byte_d     = byte_q;
        tmr_d      = tmr_q;
        rem_d      = rem_q;
        is_wr_d    = is_wr_q;
        is_burst_d = is_burst_q;
        lbus_a_d   = lbus_a_q;
        lbus_di_d  = lbus_di_q;
        rbuf_d     = rbuf_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        wd_d       = wd_q;
        err_d      = err_q;
`ifdef LBUS_WAIT_EN
        ext_d      = 8'd0;
`endif

        if (fetch_st) begin
            case (ph_q)
                2'd0:    ph_d = rd_busy ? 2'd0 : 2'd1;
                2'd1:    ph_d = 2'd2;
                default: ph_d = 2'd0;
            endcase
            re_d = (ph_q == 2'd0) && !rd_busy;
        end

        if (state_d != state_q)
            byte_d = 4'd0;
        else if ((state_q == S_ADDR || state_q == S_WDATA) && byte_rdy)
            byte_d = byte_q + 4'd1;
        else if (state_q == S_RDOUT && !wr_busy)
            byte_d = byte_q + 4'd1;

        if (state_d == S_SETUP && state_q != S_SETUP)
            tmr_d = SETUP_LD;
        else if (state_d == S_STROBE && state_q != S_STROBE)
            tmr_d = STROBE_LD;
        else if (tmr_q != 16'd0)
            tmr_d = tmr_q - 16'd1;

        case (state_q)
            S_CMD: begin
                if (byte_rdy) begin
                    if (bus.rd == 8'hFF) begin
                        err_d = 1'b0;
                    end else if (bus.rd[7:2] != 6'd0) begin
                        err_d = 1'b1;
                    end else begin
                        is_wr_d    = bus.rd[0];
                        is_burst_d = bus.rd[1];
                        rem_d      = 9'd1;
                    end
                end
            end
            S_ADDR: begin
                if (byte_rdy) lbus_a_d = (lbus_a_q << 8) | ADDR_W'(bus.rd);
            end
            S_LEN: begin
                if (byte_rdy) rem_d = {1'b0, bus.rd} + 9'd1;
            end
            S_WDATA: begin
                if (byte_rdy) lbus_di_d = (lbus_di_q << 8) | DATA_W'(bus.rd);
            end
            S_STROBE: begin
                if (wait_abort) err_d = 1'b1;
                else if (strobe_end) rbuf_d = bus.lbus_do;
`ifdef LBUS_WAIT_EN
                if (tmr_q == 16'd0 && bus.lbus_wait) ext_d = ext_q + 8'd1;
`endif
            end
            S_RDOUT: begin
                if (!wr_busy) begin
                    we_d   = 1'b1;
                    wd_d   = rbuf_q[DATA_W-1 -: 8];
                    rbuf_d = rbuf_q << 8;
                end
            end
            S_NEXT: begin
                lbus_a_d = lbus_a_q + ADDR_W'(1);
                rem_d    = rem_q - 9'd1;
            end
            default: ;
        endcase

        // strobes follow the next state so they are low exactly while in STROBE
        rdn_d = !(state_d == S_STROBE && !is_wr_q);
        wrn_d = !(state_d == S_STROBE && is_wr_q);
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ph_q       <= 2'd0;
            byte_q     <= 4'd0;
            tmr_q      <= 16'd0;
            rem_q      <= 9'd0;
            is_wr_q    <= 1'b0;
            is_burst_q <= 1'b0;
            lbus_a_q   <= '0;
            lbus_di_q  <= '0;
            rbuf_q     <= '0;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            wd_q       <= 8'd0;
            err_q      <= 1'b0;
`ifdef LBUS_WAIT_EN
            ext_q      <= 8'd0;
`endif
        end else begin
            ph_q       <= ph_d;
            byte_q     <= byte_d;
            tmr_q      <= tmr_d;
            rem_q      <= rem_d;
            is_wr_q    <= is_wr_d;
            is_burst_q <= is_burst_d;
            lbus_a_q   <= lbus_a_d;
            lbus_di_q  <= lbus_di_d;
            rbuf_q     <= rbuf_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
            re_q       <= re_d;
            we_q       <= we_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
`ifdef LBUS_WAIT_EN
            ext_q      <= ext_d;
`endif
        end
    end

    assign bus.lbus_a   = lbus_a_q;
    assign bus.lbus_di  = lbus_di_q;
    assign bus.lbus_rdn = rdn_q;
    assign bus.lbus_wrn = wrn_q;
    assign bus.re       = re_q;
    assign bus.we       = we_q;
    assign bus.wd       = wd_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ctrl_lbus_burst.sv
// tb_ctrl_lbus_burst: directed bench for ctrl_lbus_burst with a registered-read
// RX FIFO model, a TX FIFO log and a local-bus monitor that records every
// strobe (address, data, low width, cycles since the last re pulse).
module tb_ctrl_lbus_burst;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_lbus_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if();

    ctrl_lbus_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(4), .STROBE_CYC(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int n_chk = 0;
    int n_err = 0;

    // RX FIFO model: data appears on rd the cycle after re
    logic [7:0] rx_mem [0:63];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic [7:0] rd_q  = 8'h00;
    always @(posedge clk) begin
        if (bus_if.re) begin
            rd_q  <= rx_mem[rx_rd % 64];
            rx_rd <= rx_rd + 1;
        end
    end
    assign bus_if.rd   = rd_q;
    assign bus_if.emp  = (rx_wr == rx_rd);
    assign bus_if.aemp = ((rx_wr - rx_rd) <= 1);

    // TX FIFO log
    logic [7:0] tx_mem [0:63];
    int         tx_cnt = 0;
    logic       ful_r  = 1'b0;
    always @(posedge clk) begin
        if (bus_if.we) begin
            tx_mem[tx_cnt % 64] <= bus_if.wd;
            tx_cnt <= tx_cnt + 1;
        end
    end
    assign bus_if.ful  = ful_r;
    assign bus_if.aful = 1'b0;

    // crypto-core read model
    assign bus_if.lbus_do = (bus_if.lbus_a == 16'h000C) ? 16'hABCD : (bus_if.lbus_a ^ 16'h5A5A);

`ifdef LBUS_WAIT_EN
    logic wait_r = 1'b0;
    assign bus_if.lbus_wait = wait_r;
`endif

    // bus monitor
    logic [15:0] log_a   [0:31];
    logic [15:0] log_d   [0:31];
    logic        log_wr  [0:31];
    int          log_low [0:31];
    int          log_gap [0:31];
    int          n_bus = 0, since_re = 0, low_len = 0, fall_cnt = 0;
    int          stab_err = 0, re_emp_err = 0;
    logic        str_prev = 1'b0;
    logic [15:0] cur_a, cur_di;
    always @(negedge clk) begin
        logic str;
        str = !bus_if.lbus_rdn || !bus_if.lbus_wrn;
        if (bus_if.re && bus_if.emp) re_emp_err++;
        if (str && !str_prev) begin
            fall_cnt++;
            cur_a  = bus_if.lbus_a;
            cur_di = bus_if.lbus_di;
            log_a[n_bus % 32]   = bus_if.lbus_a;
            log_wr[n_bus % 32]  = !bus_if.lbus_wrn;
            log_d[n_bus % 32]   = !bus_if.lbus_wrn ? bus_if.lbus_di : bus_if.lbus_do;
            log_gap[n_bus % 32] = since_re;
            low_len = 1;
        end else if (str) begin
            low_len++;
            if (bus_if.lbus_a != cur_a || bus_if.lbus_di != cur_di) stab_err++;
        end else if (str_prev) begin
            log_low[n_bus % 32] = low_len;
            n_bus++;
        end
        if (bus_if.re) since_re = 0;
        else           since_re++;
        str_prev = str;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr % 64] = b;
        rx_wr++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(bus_if.busy == 1'b0 && rx_wr == rx_rd) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_tx(input string tag, input int target, input int budget);
        int n = 0;
        while (tx_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_rdn_low(input string tag, input int budget);
        int n = 0;
        while (bus_if.lbus_rdn && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int b, t, f0;
        logic [15:0] br_a [0:2];
        logic [7:0]  br_tx [0:5];
        br_a  = '{16'hFFFE, 16'hFFFF, 16'h0000};
        br_tx = '{8'hA5, 8'hA4, 8'hA5, 8'hA5, 8'h5A, 8'h5A};

        rst = 1'b0;
        repeat (3) tick();
        chk("rst_strobes", 32'({bus_if.lbus_rdn, bus_if.lbus_wrn}), 32'h3);
        chk("rst_flags", 32'({bus_if.busy, bus_if.err, bus_if.re, bus_if.we}), 32'h0);
        chk("rst_a", 32'(bus_if.lbus_a), 32'h0);
        chk("rst_di", 32'(bus_if.lbus_di), 32'h0);
        chk("rst_wd", 32'(bus_if.wd), 32'h0);
        rst = 1'b1;
        tick();

        // single write 01 00 02 12 34
        b = n_bus;
        push(8'h01); push(8'h00); push(8'h02); push(8'h12); push(8'h34);
        wait_done("wr1", 300);
        chk("wr1_cycles", n_bus - b, 1);
        chk("wr1_addr", 32'(log_a[b % 32]), 32'h0002);
        chk("wr1_data", 32'(log_d[b % 32]), 32'h1234);
        chk("wr1_is_wr", 32'(log_wr[b % 32]), 32'h1);
        chk("wr1_low", log_low[b % 32], 4);
        chk("wr1_gap", log_gap[b % 32], 5);
        chk("wr1_busy", 32'(bus_if.busy), 32'h0);

        // single read 00 00 0C
        b = n_bus; t = tx_cnt;
        push(8'h00); push(8'h00); push(8'h0C);
        wait_done("rd1", 300);
        chk("rd1_cycles", n_bus - b, 1);
        chk("rd1_addr", 32'(log_a[b % 32]), 32'h000C);
        chk("rd1_is_wr", 32'(log_wr[b % 32]), 32'h0);
        chk("rd1_low", log_low[b % 32], 4);
        chk("rd1_gap", log_gap[b % 32], 6);
        chk("rd1_txn", tx_cnt - t, 2);
        chk("rd1_tx0", 32'(tx_mem[t % 64]), 32'hAB);
        chk("rd1_tx1", 32'(tx_mem[(t + 1) % 64]), 32'hCD);

        // burst read with wrap, ful held 20 cycles after the first word
        b = n_bus; t = tx_cnt;
        push(8'h02); push(8'hFF); push(8'hFE); push(8'h02);
        wait_tx("br_first", t + 2, 300);
        ful_r = 1'b1;
        f0 = fall_cnt;
        repeat (20) tick();
        chk("br_stall_tx", tx_cnt - t, 2);
        chk("br_stall_falls", fall_cnt - f0, 1);
        ful_r = 1'b0;
        wait_done("br", 400);
        chk("br_cycles", n_bus - b, 3);
        chk("br_gap", log_gap[b % 32], 6);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("br_addr%0d", i), 32'(log_a[(b + i) % 32]), 32'(br_a[i]));
            chk($sformatf("br_low%0d", i), log_low[(b + i) % 32], 4);
        end
        chk("br_txn", tx_cnt - t, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("br_tx%0d", i), 32'(tx_mem[(t + i) % 64]), 32'(br_tx[i]));

        // burst write with starved RX between words
        b = n_bus;
        push(8'h03); push(8'h00); push(8'h10); push(8'h01); push(8'hAA); push(8'hBB);
        begin
            int n = 0;
            while (rx_wr != rx_rd && n < 300) begin tick(); n++; end
            if (n >= 300) chk("bw_drain_timeout", 32'd1, 32'd0);
        end
        repeat (10) tick();
        chk("bw_stall_busy", 32'(bus_if.busy), 32'h1);
        push(8'hCC); push(8'hDD);
        wait_done("bw", 300);
        chk("bw_cycles", n_bus - b, 2);
        chk("bw_addr0", 32'(log_a[b % 32]), 32'h0010);
        chk("bw_data0", 32'(log_d[b % 32]), 32'hAABB);
        chk("bw_addr1", 32'(log_a[(b + 1) % 32]), 32'h0011);
        chk("bw_data1", 32'(log_d[(b + 1) % 32]), 32'hCCDD);
        chk("bw_is_wr1", 32'(log_wr[(b + 1) % 32]), 32'h1);
        chk("bw_low1", log_low[(b + 1) % 32], 4);
        chk("bw_gap1", log_gap[(b + 1) % 32], 5);
        chk("bw_re_emp", re_emp_err, 0);

        // bad command, clear, then a normal read
        b = n_bus; t = tx_cnt;
        push(8'h07);
        wait_done("bad", 100);
        chk("bad_err", 32'(bus_if.err), 32'h1);
        chk("bad_cycles", n_bus - b, 0);
        push(8'hFF);
        wait_done("clr", 100);
        chk("clr_err", 32'(bus_if.err), 32'h0);
        push(8'h00); push(8'h00); push(8'h00);
        wait_done("rd0", 300);
        chk("rd0_addr", 32'(log_a[b % 32]), 32'h0000);
        chk("rd0_txn", tx_cnt - t, 2);
        chk("rd0_tx0", 32'(tx_mem[t % 64]), 32'h5A);
        chk("rd0_tx1", 32'(tx_mem[(t + 1) % 64]), 32'h5A);

        // reset while the read strobe is low
        t = tx_cnt;
        push(8'h00); push(8'h00); push(8'h0C);
        wait_rdn_low("rst_mid", 300);
        tick();
        rst = 1'b0;
        tick();
        chk("rstm_strobes", 32'({bus_if.lbus_rdn, bus_if.lbus_wrn}), 32'h3);
        chk("rstm_flags", 32'({bus_if.busy, bus_if.err, bus_if.re, bus_if.we}), 32'h0);
        chk("rstm_a", 32'(bus_if.lbus_a), 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        chk("rstm_txn", tx_cnt - t, 0);
        push(8'h00); push(8'h00); push(8'h0C);
        wait_done("rd2", 300);
        chk("rd2_txn", tx_cnt - t, 2);
        chk("rd2_tx0", 32'(tx_mem[t % 64]), 32'hAB);
        chk("rd2_tx1", 32'(tx_mem[(t + 1) % 64]), 32'hCD);
        chk("stability", stab_err, 0);

`ifdef LBUS_WAIT_EN
        // wait held for 10 samples after the base width
        b = n_bus;
        push(8'h00); push(8'h00); push(8'h0C);
        wait_rdn_low("wt", 300);
        repeat (3) tick();
        wait_r = 1'b1;
        repeat (10) tick();
        wait_r = 1'b0;
        wait_done("wt", 300);
        chk("wt_low", log_low[b % 32], 14);

        // wait stuck high: abort after 4+255 low cycles
        b = n_bus; t = tx_cnt;
        wait_r = 1'b1;
        push(8'h00); push(8'h00); push(8'h0C);
        wait_done("ab", 800);
        wait_r = 1'b0;
        chk("ab_low", log_low[b % 32], 259);
        chk("ab_err", 32'(bus_if.err), 32'h1);
        chk("ab_txn", tx_cnt - t, 0);
        push(8'hFF);
        wait_done("ab_clr", 100);
        chk("ab_clr_err", 32'(bus_if.err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
